// File: rtl/row_skewer_stream.sv
// ---------------------------------------------------------------------------
// row_skewer_stream
//
// Purpose:
//   Row skewer for the systolic array feed path. Accepts one DIM_SIZE x
//   DIM_SIZE matrix (packed rows) per input handshake and streams it out as
//   2*DIM_SIZE-1 diagonal wavefronts, one per accepted output beat.
//   Wavefront k, lane r = element (k-r) of row r when 0 <= k-r < DIM_SIZE,
//   otherwise zero. Elements and lanes are packed MSB first.
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst        synchronous reset, active-high
//   in_valid   matrix present on in_rows
//   in_ready   block accepts a matrix this cycle
//   in_rows    DIM_SIZE packed rows, row r at [(r+1)*DATA_WIDTH-1 : r*DATA_WIDTH]
//   out_valid  out_diag holds a valid wavefront
//   out_ready  consumer accepts the wavefront this cycle
//   out_diag   wavefront, lane r feeds array row r
//   out_idx    wavefront number k, 0..2*DIM_SIZE-2
//   out_last   high with the final wavefront
//   busy       a matrix is held (streaming or buffered)
//
// Configuration:
//   ROW_SKEWER_DBUF_EN  when defined, adds a shadow matrix buffer so that
//                       back-to-back matrices stream without a bubble cycle.
//                       When undefined, a single buffer is used and in_ready
//                       is low for the whole streaming phase.
// ---------------------------------------------------------------------------
module row_skewer_stream #(
    parameter int DATA_SIZE  = 8,
    parameter int DIM_SIZE   = 4,
    parameter int DATA_WIDTH = DATA_SIZE * DIM_SIZE,
    parameter int IDX_W      = $clog2(2 * DIM_SIZE - 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DIM_SIZE*DATA_WIDTH-1:0] in_rows,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_diag,
    output logic [IDX_W-1:0]               out_idx,
    output logic                           out_last,
    output logic                           busy
);

    localparam int              LAST   = 2 * DIM_SIZE - 2;
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(LAST);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                         state;
    logic [IDX_W-1:0]               k;
    logic [DIM_SIZE*DATA_WIDTH-1:0] active_buf;
    logic [DATA_WIDTH-1:0]          diag;
    logic                           last_beat;

`ifdef ROW_SKEWER_DBUF_EN
    logic [DIM_SIZE*DATA_WIDTH-1:0] shadow_buf;
    logic                           shadow_full;

    assign in_ready = !shadow_full;
    assign busy     = (state == STREAM) || shadow_full;
`else
    assign in_ready = (state == IDLE);
    assign busy     = (state == STREAM);
`endif

    assign out_valid = (state == STREAM);
    assign last_beat = (k == LAST_K);

    // Pure element routing: lane r picks element e of row r where r+e == k.
    always_comb begin
        diag = '0;
        for (int r = 0; r < DIM_SIZE; r++) begin
            for (int e = 0; e < DIM_SIZE; e++) begin
                if (int'(k) == r + e) begin
                    diag[DATA_WIDTH-1-r*DATA_SIZE -: DATA_SIZE] =
                        active_buf[r*DATA_WIDTH + DATA_WIDTH-1-e*DATA_SIZE -: DATA_SIZE];
                end
            end
        end
    end

    // Outputs are forced to zero whenever no wavefront is being presented.
    assign out_diag = out_valid ? diag : '0;
    assign out_idx  = out_valid ? k : '0;
    assign out_last = out_valid && last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            active_buf <= '0;
`ifdef ROW_SKEWER_DBUF_EN
            shadow_buf  <= '0;
            shadow_full <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        active_buf <= in_rows;
                        k          <= '0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (last_beat) begin
`ifdef ROW_SKEWER_DBUF_EN
                            // Chain the next matrix directly into active so
                            // its wavefront 0 follows without a gap.
                            if (shadow_full) begin
                                active_buf  <= shadow_buf;
                                shadow_full <= 1'b0;
                                k           <= '0;
                            end else if (in_valid) begin
                                active_buf <= in_rows;
                                k          <= '0;
                            end else begin
                                k     <= '0;
                                state <= IDLE;
                            end
`else
                            k     <= '0;
                            state <= IDLE;
`endif
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
`ifdef ROW_SKEWER_DBUF_EN
                    // A matrix arriving mid-stream parks in the shadow buffer;
                    // on the last beat it was already routed to active above.
                    if (in_valid && in_ready && !(out_ready && last_beat)) begin
                        shadow_buf  <= in_rows;
                        shadow_full <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_row_skewer_stream.sv
// ---------------------------------------------------------------------------
// tb_row_skewer_stream
//
// Purpose:
//   Directed scoreboard bench for row_skewer_stream (DATA_SIZE=8, DIM_SIZE=4).
//   Stimulus pushes hand-computed wavefronts into a queue; a monitor on the
//   falling edge compares every presented wavefront against the queue head
//   and pops on transfer. Back-to-back behaviour is exercised according to
//   whether ROW_SKEWER_DBUF_EN is defined.
// ---------------------------------------------------------------------------
module tb_row_skewer_stream;

    localparam int DS  = 8;
    localparam int DIM = 4;
    localparam int DW  = DS * DIM;
    localparam int IW  = 3;

    localparam logic [DIM*DW-1:0] MAT_A = 128'h0D0E0F10_090A0B0C_05060708_01020304;
    localparam logic [DIM*DW-1:0] MAT_F = {(DIM*DW){1'b1}};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DIM*DW-1:0] in_rows = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_diag;
    logic [IW-1:0]     out_idx;
    logic              out_last;
    logic              busy;

    row_skewer_stream #(.DATA_SIZE(DS), .DIM_SIZE(DIM)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rows(in_rows),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_diag(out_diag), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] diag;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Hand-computed wavefront tables.
    logic [DW-1:0] diag_a [7] = '{32'h01000000, 32'h02050000, 32'h03060900, 32'h04070A0D,
                                  32'h00080B0E, 32'h00000C0F, 32'h00000010};
    logic [DW-1:0] diag_f [7] = '{32'hFF000000, 32'hFFFF0000, 32'hFFFFFF00, 32'hFFFFFFFF,
                                  32'h00FFFFFF, 32'h0000FFFF, 32'h000000FF};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input bit ones);
        beat_t b;
        for (int i = 0; i < 7; i++) begin
            b.diag = ones ? diag_f[i] : diag_a[i];
            b.idx  = IW'(i);
            b.last = (i == 6);
            exp_q.push_back(b);
        end
    endtask

    // Monitor: state shared with stimulus for latency/gap measurements.
    bit expect_start = 1'b1;
    int last_cyc  = 0;
    int start_cyc = 0;
    int gap       = 0;

    always @(negedge clk) begin
        beat_t b;
        if (out_valid) begin
            if (expect_start) begin
                start_cyc    = cyc;
                gap          = cyc - last_cyc;
                expect_start = 1'b0;
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {out_diag, out_idx, out_last}, 64'd0);
            end else begin
                b = exp_q[0];
                chk("diag", out_diag, b.diag);
                chk("idx",  out_idx,  b.idx);
                chk("last", out_last, b.last);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (b.last) begin
                        last_cyc     = cyc;
                        expect_start = 1'b1;
                    end
                end
            end
        end else begin
            chk("idle_outputs_zero", {out_diag, out_idx, out_last}, 64'd0);
        end
    end

    task automatic send(input logic [DIM*DW-1:0] m);
        int n = 0;
        in_rows  = m;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_outputs",   {out_diag, out_idx, out_last}, 0);

        // 1: reference matrix, consumer always ready
        out_ready = 1'b1;
        push_exp(1'b0);
        send(MAT_A);
        chk("t1_busy_streaming", busy, 1);
        wait_drain(50);
        chk("t1_busy_after", busy, 0);
        chk("t1_in_ready_after", in_ready, 1);

        // 2: consumer toggles ready every cycle
        push_exp(1'b0);
        out_ready = 1'b1;
        send(MAT_A);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            n++;
        end
        chk("t2_drain", exp_q.size(), 0);
        chk("t2_span_cycles", last_cyc - start_cyc + 1, 13);
        out_ready = 1'b1;
        @(posedge clk); #1;

`ifdef ROW_SKEWER_DBUF_EN
        // 4: two matrices back-to-back through the shadow buffer
        push_exp(1'b0);
        push_exp(1'b1);
        send(MAT_A);
        send(MAT_F);
        chk("t4_busy", busy, 1);
        wait_drain(60);
        chk("t4_gap_cycles", gap, 1);
        chk("t4_busy_after", busy, 0);
`else
        // 3: second matrix offered during streaming, one bubble expected
        push_exp(1'b0);
        push_exp(1'b1);
        in_rows  = MAT_A;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_rows = MAT_F;
        n = 0;
        while (!in_ready && n < 50) begin
            if (out_valid) chk("t3_in_ready_low", in_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        chk("t3_in_ready_returns", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain(60);
        chk("t3_gap_cycles", gap, 2);
`endif

        // 5: reset in the middle of a stream
        push_exp(1'b0);
        out_ready = 1'b1;
        send(MAT_A);
        n = 0;
        while (out_idx != 3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_reach_k3", out_idx, 3);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        expect_start = 1'b1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy",      busy,      0);
        chk("t5_in_ready",  in_ready,  1);

        // 6: all-ones matrix after the reset, streams from k=0
        out_ready = 1'b1;
        push_exp(1'b1);
        send(MAT_F);
        wait_drain(50);
        chk("t6_busy_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
